mem_pe_master: RTL and testbench

- Initiator-side controller for the Mem_PE word memory; it is the command/request end of the memory port.
- Accepts single-word write and burst read commands over a valid/ready command channel.
- Sequences the memory address, data and enable pins.
- Returns write acknowledges and read data over a valid/ready response channel with backpressure.

---
 rtl/mem_pe_pkg.sv | 21 ++
 rtl/mem_pe_master.sv | 158 +++++++++++++++
 tb/tb_mem_pe_master.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pe_pkg.sv
// Shared types and default sizes for the Mem_PE initiator-side controller.
package mem_pe_pkg;

    localparam int unsigned WORDSIZE = 16;
    localparam int unsigned MEMSIZE  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic                is_wr;
        logic [MEMSIZE-1:0]  addr;
        logic [WORDSIZE-1:0] rdata;
        logic                last;
    } rsp_t;

endpackage

// File: rtl/mem_pe_master.sv
// Command/request end of the Mem_PE port: single-word writes, wrapping burst
// reads, one command outstanding, valid/ready response channel with backpressure.
module mem_pe_master
    import mem_pe_pkg::*;
#(
    parameter int unsigned wordsize   = WORDSIZE,
    parameter int unsigned memsize    = MEMSIZE,
    parameter int unsigned rd_latency = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic                i_cmd_we,
    input  logic [memsize-1:0]  i_cmd_addr,
    input  logic [memsize-1:0]  i_cmd_len,
    input  logic [wordsize-1:0] i_cmd_wdata,
    output logic                o_mem_en,
    output logic                o_mem_we,
    output logic [memsize-1:0]  o_mem_addr,
    output logic [wordsize-1:0] o_mem_data_in,
    input  logic [wordsize-1:0] i_mem_data_out,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic                o_rsp_is_wr,
    output logic [memsize-1:0]  o_rsp_addr,
    output logic [wordsize-1:0] o_rsp_rdata,
    output logic                o_rsp_last,
    output logic                o_busy
);

    // rd_latency is 1..4, so the wait counter only ever holds 0..3
    localparam int unsigned CNT_W = 2;

    state_t                r_state, w_next;
    logic                  r_we, w_we_d;
    logic [memsize-1:0]    r_addr, w_addr_d;
    logic [memsize-1:0]    r_remain, w_remain_d;
    logic [wordsize-1:0]   r_wdata, w_wdata_d;
    logic [CNT_W-1:0]      r_cnt, w_cnt_d;
    rsp_t                  r_rsp, w_rsp_d;

    logic                  r_cmd_ready, r_mem_en, r_mem_we, r_rsp_valid, r_busy;
    logic [memsize-1:0]    r_mem_addr, w_mem_addr_d;
    logic [wordsize-1:0]   r_mem_data_in, w_mem_data_in_d;
    logic                  w_issue;

    // Next-state, datapath updates and next values of the registered pins
    always_comb begin
        w_next     = r_state;
        w_we_d     = r_we;
        w_addr_d   = r_addr;
        w_remain_d = r_remain;
        w_wdata_d  = r_wdata;
        w_cnt_d    = r_cnt;
        w_rsp_d    = r_rsp;

        case (r_state)
            IDLE: begin
                if (i_cmd_valid && r_cmd_ready) begin
                    w_we_d     = i_cmd_we;
                    w_addr_d   = i_cmd_addr;
                    w_remain_d = i_cmd_we ? '0 : i_cmd_len;
                    w_wdata_d  = i_cmd_wdata;
                    w_next     = ISSUE;
                end
            end
            ISSUE: begin
                if (r_we) begin
                    w_rsp_d.is_wr = 1'b1;
                    w_rsp_d.addr  = r_addr;
                    w_rsp_d.rdata = '0;
                    w_rsp_d.last  = 1'b1;
                    w_next        = RESP;
                end else begin
                    w_cnt_d = CNT_W'(rd_latency - 1);
                    w_next  = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_rsp_d.is_wr = 1'b0;
                    w_rsp_d.addr  = r_addr;
                    w_rsp_d.rdata = i_mem_data_out;
                    w_rsp_d.last  = (r_remain == '0);
                    w_next        = RESP;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    if (!r_we && (r_remain != '0)) begin
                        w_remain_d = r_remain - 1'b1;
                        w_addr_d   = r_addr + 1'b1;
                        w_next     = ISSUE;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase

        // Memory pins are only driven in ISSUE; address and data hold otherwise
        w_issue         = (w_next == ISSUE);
        w_mem_addr_d    = w_issue ? w_addr_d : r_mem_addr;
        w_mem_data_in_d = w_issue ? (w_we_d ? w_wdata_d : '0) : r_mem_data_in;
    end

    // State, datapath and output registers; reset aborts any command in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_remain      <= '0;
            r_wdata       <= '0;
            r_cnt         <= '0;
            r_rsp         <= '0;
            r_cmd_ready   <= 1'b0;
            r_mem_en      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data_in <= '0;
            r_rsp_valid   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_we          <= w_we_d;
            r_addr        <= w_addr_d;
            r_remain      <= w_remain_d;
            r_wdata       <= w_wdata_d;
            r_cnt         <= w_cnt_d;
            r_rsp         <= w_rsp_d;
            r_cmd_ready   <= (w_next == IDLE);
            r_mem_en      <= w_issue;
            r_mem_we      <= w_issue && w_we_d;
            r_mem_addr    <= w_mem_addr_d;
            r_mem_data_in <= w_mem_data_in_d;
            r_rsp_valid   <= (w_next == RESP);
            r_busy        <= (w_next != IDLE);
        end
    end

    assign o_cmd_ready   = r_cmd_ready;
    assign o_mem_en      = r_mem_en;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_data_in = r_mem_data_in;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_is_wr   = r_rsp.is_wr;
    assign o_rsp_addr    = r_rsp.addr;
    assign o_rsp_rdata   = r_rsp.rdata;
    assign o_rsp_last    = r_rsp.last;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_mem_pe_master.sv
// Bench for mem_pe_master: memory models, response scoreboard, directed timing checks.
module tb_mem_pe_master;

    typedef struct packed {
        logic        is_wr;
        logic [2:0]  addr;
        logic [15:0] rdata;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [2:0]  cmd_addr, cmd_len;
    logic [15:0] cmd_wdata;
    logic        mem_en, mem_we;
    logic [2:0]  mem_addr;
    logic [15:0] mem_data_in, mem_data_out;
    logic        rsp_valid, rsp_ready, rsp_is_wr, rsp_last, busy;
    logic [2:0]  rsp_addr;
    logic [15:0] rsp_rdata;

    logic        d3_cmd_valid, d3_cmd_ready, d3_cmd_we;
    logic [2:0]  d3_cmd_addr, d3_cmd_len;
    logic [15:0] d3_cmd_wdata;
    logic        d3_mem_en, d3_mem_we;
    logic [2:0]  d3_mem_addr;
    logic [15:0] d3_mem_data_in, d3_mem_data_out;
    logic        d3_rsp_valid, d3_rsp_ready, d3_rsp_is_wr, d3_rsp_last, d3_busy;
    logic [2:0]  d3_rsp_addr;
    logic [15:0] d3_rsp_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mem_pe_master u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
        .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len), .i_cmd_wdata(cmd_wdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_data_in(mem_data_in), .i_mem_data_out(mem_data_out),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_is_wr(rsp_is_wr),
        .o_rsp_addr(rsp_addr), .o_rsp_rdata(rsp_rdata), .o_rsp_last(rsp_last),
        .o_busy(busy)
    );

    mem_pe_master #(.rd_latency(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(d3_cmd_valid), .o_cmd_ready(d3_cmd_ready), .i_cmd_we(d3_cmd_we),
        .i_cmd_addr(d3_cmd_addr), .i_cmd_len(d3_cmd_len), .i_cmd_wdata(d3_cmd_wdata),
        .o_mem_en(d3_mem_en), .o_mem_we(d3_mem_we), .o_mem_addr(d3_mem_addr),
        .o_mem_data_in(d3_mem_data_in), .i_mem_data_out(d3_mem_data_out),
        .o_rsp_valid(d3_rsp_valid), .i_rsp_ready(d3_rsp_ready), .o_rsp_is_wr(d3_rsp_is_wr),
        .o_rsp_addr(d3_rsp_addr), .o_rsp_rdata(d3_rsp_rdata), .o_rsp_last(d3_rsp_last),
        .o_busy(d3_busy)
    );

    function automatic logic [15:0] init_word(input int i);
        if (i == 1) return 16'h1234;
        return 16'hC000 + 16'(i) * 16'h0101;
    endfunction

    // Mem_PE model, 1-cycle read latency
    logic [15:0] mem [8];
    logic [15:0] rd_pipe;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= init_word(i);
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_data_in;
        end
        rd_pipe <= (mem_en && !mem_we) ? mem[mem_addr] : 16'h0;
    end
    assign mem_data_out = rd_pipe;

    // Mem_PE model, 3-cycle read latency
    logic [15:0] mem3 [8];
    logic [15:0] p3 [3];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem3[i] <= init_word(i);
        end else if (d3_mem_en && d3_mem_we) begin
            mem3[d3_mem_addr] <= d3_mem_data_in;
        end
        p3[0] <= (d3_mem_en && !d3_mem_we) ? mem3[d3_mem_addr] : 16'h0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign d3_mem_data_out = p3[2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] outs1();
        return 64'({cmd_ready, mem_en, mem_we, mem_addr, mem_data_in, rsp_valid,
                    rsp_is_wr, rsp_addr, rsp_rdata, rsp_last, busy});
    endfunction

    function automatic logic [63:0] outs3();
        return 64'({d3_cmd_ready, d3_mem_en, d3_mem_we, d3_mem_addr, d3_mem_data_in,
                    d3_rsp_valid, d3_rsp_is_wr, d3_rsp_addr, d3_rsp_rdata, d3_rsp_last,
                    d3_busy});
    endfunction

    // Response monitor: every handshake pops and compares one expected beat
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_is_wr", 64'(rsp_is_wr), 64'(e.is_wr));
                chk("rsp_addr",  64'(rsp_addr),  64'(e.addr));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_last",  64'(rsp_last),  64'(e.last));
            end
        end
    end

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_read(input logic [2:0] addr, input logic [2:0] len);
        exp_t e;
        for (int i = 0; i <= int'(len); i++) begin
            e.is_wr = 1'b0;
            e.addr  = addr + 3'(i);
            e.rdata = mem[e.addr];
            e.last  = (i == int'(len));
            sb_q.push_back(e);
        end
    endtask

    task automatic push_write(input logic [2:0] addr);
        exp_t e;
        e.is_wr = 1'b1;
        e.addr  = addr;
        e.rdata = 16'h0;
        e.last  = 1'b1;
        sb_q.push_back(e);
    endtask

    // Presents one command; returns in the cycle after acceptance (T+1)
    task automatic send_cmd(input logic we, input logic [2:0] addr, input logic [2:0] len,
                            input logic [15:0] wd);
        int n = 0;
        while (!cmd_ready && n < 50) begin step(); n++; end
        if (!cmd_ready) chk("cmd_ready_timeout", 64'd0, 64'd1);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_wdata = wd;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin step(); n++; end
        chk("drain", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int en_cnt;
        rst = 1'b1;
        cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_len = 0; cmd_wdata = 0; rsp_ready = 1'b1;
        d3_cmd_valid = 0; d3_cmd_we = 0; d3_cmd_addr = 0; d3_cmd_len = 0; d3_cmd_wdata = 0;
        d3_rsp_ready = 1'b1;

        // Reset from power-up
        repeat (3) step();
        chk("reset_outs", outs1(), 64'd0);
        chk("reset_outs_l3", outs3(), 64'd0);
        rst = 1'b0;
        step();
        chk("ready_after_reset", 64'(cmd_ready), 64'd1);
        chk("busy_after_reset", 64'(busy), 64'd0);

        // Single read, L=1
        push_read(3'd1, 3'd0);
        send_cmd(1'b0, 3'd1, 3'd0, 16'h0);
        chk("rd_mem_en", 64'(mem_en), 64'd1);
        chk("rd_mem_we", 64'(mem_we), 64'd0);
        chk("rd_mem_addr", 64'(mem_addr), 64'd1);
        chk("rd_busy", 64'(busy), 64'd1);
        step();
        chk("rd_valid_t2", 64'(rsp_valid), 64'd0);
        chk("rd_mem_en_t2", 64'(mem_en), 64'd0);
        step();
        chk("rd_valid_t3", 64'(rsp_valid), 64'd1);
        chk("rd_data_t3", 64'(rsp_rdata), 64'h1234);
        chk("rd_last_t3", 64'(rsp_last), 64'd1);
        drain();

        // Single write
        push_write(3'd1);
        send_cmd(1'b1, 3'd1, 3'd5, 16'hA5A5);
        chk("wr_mem_en", 64'(mem_en), 64'd1);
        chk("wr_mem_we", 64'(mem_we), 64'd1);
        chk("wr_mem_addr", 64'(mem_addr), 64'd1);
        chk("wr_mem_data", 64'(mem_data_in), 64'hA5A5);
        step();
        chk("wr_valid_t2", 64'(rsp_valid), 64'd1);
        chk("wr_is_wr_t2", 64'(rsp_is_wr), 64'd1);
        chk("wr_last_t2", 64'(rsp_last), 64'd1);
        chk("wr_mem_en_t2", 64'(mem_en), 64'd0);
        step();
        chk("wr_mem_content", 64'(mem[1]), 64'hA5A5);
        drain();

        // Wrapping burst 6,7,0,1
        push_read(3'd6, 3'd3);
        send_cmd(1'b0, 3'd6, 3'd3, 16'h0);
        drain();

        // Backpressure on beat 0 with a stray command pulse during the stall
        rsp_ready = 1'b0;
        push_read(3'd4, 3'd1);
        send_cmd(1'b0, 3'd4, 3'd1, 16'h0);
        k = 0;
        while (!rsp_valid && k < 20) begin step(); k++; end
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rdata", 64'(rsp_rdata), 64'(init_word(4)));
            chk("bp_addr", 64'(rsp_addr), 64'd4);
            chk("bp_last", 64'(rsp_last), 64'd0);
            chk("bp_mem_en", 64'(mem_en), 64'd0);
            chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            cmd_valid = (c == 2); cmd_we = 1'b1; cmd_addr = 3'd5; cmd_wdata = 16'hDEAD;
            step();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();
        repeat (6) step();
        chk("bp_no_extra_rsp", 64'(rsp_valid), 64'd0);
        chk("bp_no_write", 64'(mem[5]), 64'(init_word(5)));
        chk("bp_idle", 64'(busy), 64'd0);

        // Reset in the middle of a burst (beat 0 delivered, beat 1 in ISSUE)
        push_read(3'd2, 3'd0);
        sb_q[0].last = 1'b0;
        send_cmd(1'b0, 3'd2, 3'd3, 16'h0);
        step(); step(); step();
        chk("mid_beat1_issue", 64'(mem_en), 64'd1);
        chk("mid_beat1_addr", 64'(mem_addr), 64'd3);
        rst = 1'b1;
        step();
        chk("mid_reset_outs_a", outs1(), 64'd0);
        step();
        chk("mid_reset_outs_b", outs1(), 64'd0);
        rst = 1'b0;
        step();
        chk("mid_ready_after", 64'(cmd_ready), 64'd1);
        chk("mid_busy_after", 64'(busy), 64'd0);
        en_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (mem_en || rsp_valid) en_cnt++;
            step();
        end
        chk("mid_no_activity", 64'(en_cnt), 64'd0);
        chk("mid_sb_empty", 64'(sb_q.size()), 64'd0);

        // rd_latency = 3 instance: response exactly at T+5
        k = 0;
        while (!d3_cmd_ready && k < 20) begin step(); k++; end
        d3_cmd_valid = 1'b1; d3_cmd_we = 1'b0; d3_cmd_addr = 3'd5; d3_cmd_len = 3'd0;
        step();
        d3_cmd_valid = 1'b0;
        chk("l3_mem_en_t1", 64'(d3_mem_en), 64'd1);
        k = 1;
        while (!d3_rsp_valid && k < 12) begin step(); k++; end
        chk("l3_latency", 64'(k), 64'd5);
        chk("l3_rdata", 64'(d3_rsp_rdata), 64'(init_word(5)));
        chk("l3_addr", 64'(d3_rsp_addr), 64'd5);
        chk("l3_last", 64'(d3_rsp_last), 64'd1);
        step();
        chk("l3_done", 64'(d3_rsp_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
